// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking-neuron layer:
// controller state encoding, sign-magnitude weight decode, saturating
// potential accumulation and leak-toward-zero.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Decode a (mag_w+1)-bit sign-magnitude value; negative zero decodes to 0.
  function automatic logic signed [31:0] sm_to_signed(input logic [31:0] sm,
                                                      input int          mag_w);
    logic [31:0] mask;
    logic [31:0] mag;
    mask = (32'd1 << mag_w) - 32'd1;
    mag  = sm & mask;
    if (sm[mag_w]) sm_to_signed = -$signed(mag);
    else           sm_to_signed = $signed(mag);
  endfunction

  // Add two values and clamp to the signed range of a pot_w-bit register.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 pot_w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (pot_w - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi)      sat_add = hi[31:0];
    else if (sum < lo) sat_add = lo[31:0];
    else               sat_add = sum[31:0];
  endfunction

  // Move a potential toward zero by at most leak, never crossing zero.
  function automatic logic signed [31:0] apply_leak(input logic signed [31:0] pot,
                                                    input int                 leak);
    logic signed [31:0] l;
    l = leak;
    if (pot > 0)      apply_leak = (pot < l)  ? 32'sd0 : pot - l;
    else if (pot < 0) apply_leak = (-pot < l) ? 32'sd0 : pot + l;
    else              apply_leak = pot;
  endfunction

endpackage

// File: rtl/snn_layer_lif_neuron.sv
// One integrate-and-fire neuron: membrane potential with saturating
// accumulation, leak and threshold at fire time, saturating spike counter.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int POT_W  = 16,
  parameter int THRESH = 256,
  parameter int LEAK   = 1,
  parameter int CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             acc_en,
  input  logic             fire_en,
  input  logic [WIDTH:0]   w_sm,
  output logic             spike,
  output logic [CNT_W-1:0] count
);

  logic signed [POT_W-1:0] pot_q, pot_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [31:0]      pot_ext;
  logic signed [31:0]      w_ext;
  logic signed [31:0]      leaked;

  // Widen the potential, decode the weight and evaluate the leaked potential.
  always_comb begin
    pot_ext = 32'(pot_q);
    w_ext   = sm_to_signed(32'(w_sm), WIDTH);
    leaked  = apply_leak(pot_ext, LEAK);
    spike   = fire_en && (leaked >= THRESH);
  end

  // Next potential / count: clear on frame start, add in ACCUM, leak+fire in FIRE.
  always_comb begin
    pot_d = pot_q;
    cnt_d = cnt_q;
    if (clear) begin
      pot_d = '0;
      cnt_d = '0;
    end else if (acc_en) begin
      pot_d = POT_W'(sat_add(pot_ext, w_ext, POT_W));
    end else if (fire_en) begin
      if (spike) begin
        pot_d = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        pot_d = POT_W'(leaked);
      end
    end
  end

  // Potential and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pot_q <= '0;
      cnt_q <= '0;
    end else begin
      pot_q <= pot_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/snn_layer.sv
// Layer of N_OUT integrate-and-fire neurons fed by N_IN binary pixels.
// Each timestep walks the inputs one per cycle, then fires all neurons in
// parallel; after STEPS timesteps the per-neuron spike totals are reported.
module snn_layer
  import snn_pkg::*;
#(
  parameter  int N_IN   = 7,
  parameter  int N_OUT  = 4,
  parameter  int WIDTH  = 8,
  parameter  int POT_W  = 16,
  parameter  int THRESH = 256,
  parameter  int LEAK   = 1,
  parameter  int STEPS  = 1024,
  localparam int CNT_W  = $clog2(STEPS + 1),
  localparam int IN_W   = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int OUT_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        pixels,
  input  logic                   start,
  input  logic                   w_we,
  input  logic [IN_W-1:0]        w_in,
  input  logic [OUT_W-1:0]       w_out,
  input  logic [WIDTH:0]         w_data,
  output logic                   busy,
  output logic [N_OUT-1:0]       spikes,
  output logic                   spike_valid,
  output logic                   done,
  output logic [N_OUT*CNT_W-1:0] counts
);

  localparam int N_W  = N_OUT * N_IN;
  localparam int W_AW = (N_W > 1) ? $clog2(N_W) : 1;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   i_q, i_d;
  logic [CNT_W-1:0]  t_q, t_d;
  logic [N_IN-1:0]   pix_q, pix_d;
  logic              clear;
  logic              acc_en;
  logic              fire_en;

  // Weight array, flattened as weight[out][in] at index out*N_IN + in.
  logic [WIDTH:0]    wt_q [N_W];
  logic [WIDTH:0]    wt_d [N_W];
  logic              wr_ok;
  logic [W_AW-1:0]   wr_idx;

  // Weight update: only while idle and only for in-range coordinates.
  always_comb begin
    wr_ok  = w_we && (state_q == IDLE) &&
             (int'(w_in) < N_IN) && (int'(w_out) < N_OUT);
    wr_idx = W_AW'(int'(w_out) * N_IN + int'(w_in));
    for (int k = 0; k < N_W; k++) wt_d[k] = wt_q[k];
    if (wr_ok) wt_d[wr_idx] = w_data;
  end

  // Weight registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_W; k++) wt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_W; k++) wt_q[k] <= wt_d[k];
    end
  end

  // Frame sequencer: next state, counters and per-cycle neuron controls.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    t_d         = t_q;
    pix_d       = pix_q;
    clear       = 1'b0;
    acc_en      = 1'b0;
    fire_en     = 1'b0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    spike_valid = (state_q == FIRE);
    case (state_q)
      IDLE: begin
        if (start) begin
          pix_d   = pixels;
          clear   = 1'b1;
          i_d     = '0;
          t_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = pix_q[i_q];
        if (int'(i_q) == N_IN - 1) begin
          i_d     = '0;
          state_d = FIRE;
        end else begin
          i_d = i_q + IN_W'(1);
        end
      end
      FIRE: begin
        fire_en = 1'b1;
        i_d     = '0;
        t_d     = t_q + CNT_W'(1);
        if (int'(t_q) == STEPS - 1) state_d = DONE;
        else                        state_d = ACCUM;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      t_q     <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      t_q     <= t_d;
      pix_q   <= pix_d;
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
    logic [W_AW-1:0]  sel;
    logic [CNT_W-1:0] cnt;

    assign sel = W_AW'(gi * N_IN + int'(i_q));

    lif_neuron #(
      .WIDTH (WIDTH),
      .POT_W (POT_W),
      .THRESH(THRESH),
      .LEAK  (LEAK),
      .CNT_W (CNT_W)
    ) u_neuron (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .acc_en (acc_en),
      .fire_en(fire_en),
      .w_sm   (wt_q[sel]),
      .spike  (spikes[gi]),
      .count  (cnt)
    );

    assign counts[gi*CNT_W +: CNT_W] = cnt;
  end

endmodule

// File: tb/tb_snn_layer.sv
// Directed bench for snn_layer with STEPS=16: frame results, spike timing,
// busy/done framing, ignored starts and writes, and reset behaviour.
`timescale 1ns/1ps
module tb_snn_layer;

  localparam int N_IN   = 7;
  localparam int N_OUT  = 4;
  localparam int WIDTH  = 8;
  localparam int POT_W  = 16;
  localparam int THRESH = 256;
  localparam int LEAK   = 1;
  localparam int STEPS  = 16;
  localparam int CNT_W  = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_IN-1:0]        pixels;
  logic                   start;
  logic                   w_we;
  logic [2:0]             w_in;
  logic [1:0]             w_out;
  logic [WIDTH:0]         w_data;
  logic                   busy;
  logic [N_OUT-1:0]       spikes;
  logic                   spike_valid;
  logic                   done;
  logic [N_OUT*CNT_W-1:0] counts;

  always #5 clk = ~clk;

  snn_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .POT_W(POT_W),
    .THRESH(THRESH), .LEAK(LEAK), .STEPS(STEPS)
  ) dut (
    .clk(clk), .rst(rst), .pixels(pixels), .start(start),
    .w_we(w_we), .w_in(w_in), .w_out(w_out), .w_data(w_data),
    .busy(busy), .spikes(spikes), .spike_valid(spike_valid),
    .done(done), .counts(counts)
  );

  int checks = 0;
  int errors = 0;

  // Frame log filled by run_frame.
  int         done_cyc, n_done, n_sv, sv_bad, busy_first, busy_last, pot2_nz;
  logic [3:0] spk_log [16];

  function automatic int cnt_of(input int k);
    return int'(counts[k*CNT_W +: CNT_W]);
  endfunction

  task automatic write_w(input int k, input int i, input logic [8:0] v);
    w_we = 1'b1; w_out = 2'(k); w_in = 3'(i); w_data = v;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic load_weights(input logic [8:0] a, input logic [8:0] b,
                              input logic [8:0] c, input logic [8:0] d);
    logic [8:0] vals [4];
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N_IN; i++) write_w(k, i, vals[k]);
  endtask

  // Start a frame now (cycle 0) and observe 140 cycles; optional injected
  // start/write while busy, optional write coincident with the start.
  task automatic run_frame(input logic [6:0] pix, input bit inject,
                           input bit cw_en, input int cw_out, input int cw_in,
                           input logic [8:0] cw_data);
    int t;
    done_cyc = -1; n_done = 0; n_sv = 0; sv_bad = 0;
    busy_first = -1; busy_last = -1; pot2_nz = 0;
    for (int j = 0; j < 16; j++) spk_log[j] = '0;
    pixels = pix;
    start  = 1'b1;
    if (cw_en) begin
      w_we = 1'b1; w_out = 2'(cw_out); w_in = 3'(cw_in); w_data = cw_data;
    end
    for (int cyc = 1; cyc <= 140; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      w_we  = 1'b0;
      if (inject && (cyc == 5 || cyc == 129)) start = 1'b1;
      if (inject && cyc == 10) begin
        w_we = 1'b1; w_out = 2'd0; w_in = 3'd1; w_data = 9'h0FF;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (dut.g_neuron[2].u_neuron.pot_q != 0) pot2_nz++;
      if (spike_valid) begin
        n_sv++;
        if (cyc % 8 != 0) sv_bad++;
        else begin
          t = cyc / 8 - 1;
          if (t >= 0 && t < 16) spk_log[t] = spikes;
        end
      end
    end
    start = 1'b0;
    w_we  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (spike_valid !== 1'b0) begin errors++; $display("FAIL reset_spike_valid got %b expected 0", spike_valid); end
    checks++; if (spikes !== 4'b0000) begin errors++; $display("FAIL reset_spikes got %b expected 0000", spikes); end
    checks++; if (counts !== '0) begin errors++; $display("FAIL reset_counts got %h expected 0", counts); end
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_frame_basic;
    logic [3:0]        exp;
    logic signed [15:0] p;
    load_weights(9'h03C, 9'h104, 9'h100, 9'h064);
    run_frame(7'b0101010, 1'b0, 1'b0, 0, 0, 9'h000);
    $display("frame A: done at %0d counts %0d %0d %0d %0d", done_cyc, cnt_of(0), cnt_of(1), cnt_of(2), cnt_of(3));
    checks++; if (done_cyc !== 129) begin errors++; $display("FAIL basic_done_cycle got %0d expected 129", done_cyc); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d expected 1", n_done); end
    checks++; if (busy_first !== 1) begin errors++; $display("FAIL basic_busy_first got %0d expected 1", busy_first); end
    checks++; if (busy_last !== 129) begin errors++; $display("FAIL basic_busy_last got %0d expected 129", busy_last); end
    checks++; if (n_sv !== 16 || sv_bad !== 0) begin errors++; $display("FAIL basic_spike_valid got %0d/%0d expected 16/0", n_sv, sv_bad); end
    for (int t = 0; t < 16; t++) begin
      exp = 4'b1000 | ((t % 2 == 1) ? 4'b0001 : 4'b0000);
      checks++; if (spk_log[t] !== exp) begin errors++; $display("FAIL basic_spikes_t%0d got %b expected %b", t, spk_log[t], exp); end
    end
    checks++; if (cnt_of(0) !== 8) begin errors++; $display("FAIL basic_count0 got %0d expected 8", cnt_of(0)); end
    checks++; if (cnt_of(1) !== 0) begin errors++; $display("FAIL basic_count1 got %0d expected 0", cnt_of(1)); end
    checks++; if (cnt_of(2) !== 0) begin errors++; $display("FAIL basic_count2 got %0d expected 0", cnt_of(2)); end
    checks++; if (cnt_of(3) !== 16) begin errors++; $display("FAIL basic_count3 got %0d expected 16", cnt_of(3)); end
    p = dut.g_neuron[1].u_neuron.pot_q;
    checks++; if (p !== -16'sd176) begin errors++; $display("FAIL basic_pot1 got %0d expected -176", p); end
  endtask

  task automatic test_neg_zero;
    logic signed [15:0] p;
    run_frame(7'b1111111, 1'b0, 1'b0, 0, 0, 9'h000);
    $display("frame B: done at %0d counts %0d %0d %0d %0d", done_cyc, cnt_of(0), cnt_of(1), cnt_of(2), cnt_of(3));
    checks++; if (cnt_of(0) !== 16) begin errors++; $display("FAIL negzero_count0 got %0d expected 16", cnt_of(0)); end
    checks++; if (cnt_of(2) !== 0) begin errors++; $display("FAIL negzero_count2 got %0d expected 0", cnt_of(2)); end
    checks++; if (pot2_nz !== 0) begin errors++; $display("FAIL negzero_pot2_cycles got %0d expected 0", pot2_nz); end
    checks++; if (cnt_of(3) !== 16) begin errors++; $display("FAIL negzero_count3 got %0d expected 16", cnt_of(3)); end
    p = dut.g_neuron[1].u_neuron.pot_q;
    checks++; if (p !== -16'sd432) begin errors++; $display("FAIL negzero_pot1 got %0d expected -432", p); end
  endtask

  task automatic test_busy_ignores;
    run_frame(7'b0101010, 1'b1, 1'b0, 0, 0, 9'h000);
    $display("frame A with busy-time start/write: done at %0d x%0d counts %0d %0d", done_cyc, n_done, cnt_of(0), cnt_of(3));
    checks++; if (done_cyc !== 129) begin errors++; $display("FAIL ignore_done_cycle got %0d expected 129", done_cyc); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_done_pulses got %0d expected 1", n_done); end
    checks++; if (busy_last !== 129) begin errors++; $display("FAIL ignore_busy_last got %0d expected 129", busy_last); end
    checks++; if (cnt_of(0) !== 8) begin errors++; $display("FAIL ignore_count0 got %0d expected 8", cnt_of(0)); end
    checks++; if (cnt_of(3) !== 16) begin errors++; $display("FAIL ignore_count3 got %0d expected 16", cnt_of(3)); end
  endtask

  task automatic test_threshold_boundary;
    logic [3:0]         exp;
    logic signed [15:0] p;
    load_weights(9'h000, 9'h000, 9'h000, 9'h000);
    write_w(0, 0, 9'h081);
    write_w(1, 0, 9'h080);
    write_w(2, 0, 9'h005);
    write_w(3, 0, 9'h103);
    run_frame(7'b0000001, 1'b0, 1'b0, 0, 0, 9'h000);
    $display("frame C: counts %0d %0d %0d %0d", cnt_of(0), cnt_of(1), cnt_of(2), cnt_of(3));
    for (int t = 0; t < 16; t++) begin
      exp = ((t % 2 == 1) ? 4'b0001 : 4'b0000) | ((t % 3 == 2) ? 4'b0010 : 4'b0000);
      checks++; if (spk_log[t] !== exp) begin errors++; $display("FAIL thresh_spikes_t%0d got %b expected %b", t, spk_log[t], exp); end
    end
    checks++; if (cnt_of(0) !== 8) begin errors++; $display("FAIL thresh_count0 got %0d expected 8", cnt_of(0)); end
    checks++; if (cnt_of(1) !== 5) begin errors++; $display("FAIL thresh_count1 got %0d expected 5", cnt_of(1)); end
    p = dut.g_neuron[2].u_neuron.pot_q;
    checks++; if (p !== 16'sd64) begin errors++; $display("FAIL thresh_pot2 got %0d expected 64", p); end
    p = dut.g_neuron[3].u_neuron.pot_q;
    checks++; if (p !== -16'sd32) begin errors++; $display("FAIL thresh_pot3 got %0d expected -32", p); end
  endtask

  task automatic test_out_of_range_and_coincident;
    write_w(0, 7, 9'h0FF);
    run_frame(7'b0000001, 1'b0, 1'b0, 0, 0, 9'h000);
    $display("frame C after out-of-range write: counts %0d %0d %0d %0d", cnt_of(0), cnt_of(1), cnt_of(2), cnt_of(3));
    checks++; if (cnt_of(0) !== 8) begin errors++; $display("FAIL oor_count0 got %0d expected 8", cnt_of(0)); end
    checks++; if (cnt_of(1) !== 5) begin errors++; $display("FAIL oor_count1 got %0d expected 5", cnt_of(1)); end
    run_frame(7'b0000001, 1'b0, 1'b1, 3, 0, 9'h064);
    $display("frame C with write at start: counts %0d %0d %0d %0d", cnt_of(0), cnt_of(1), cnt_of(2), cnt_of(3));
    checks++; if (cnt_of(3) !== 5) begin errors++; $display("FAIL coincident_count3 got %0d expected 5", cnt_of(3)); end
    checks++; if (cnt_of(1) !== 5) begin errors++; $display("FAIL coincident_count1 got %0d expected 5", cnt_of(1)); end
  endtask

  task automatic test_reset_midframe;
    logic signed [15:0] p;
    load_weights(9'h03C, 9'h104, 9'h100, 9'h064);
    pixels = 7'b0101010;
    start  = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (cnt_of(0) !== 2) begin errors++; $display("FAIL midframe_count0_before got %0d expected 2", cnt_of(0)); end
    checks++; if (spike_valid !== 1'b1) begin errors++; $display("FAIL midframe_fire_before got %b expected 1", spike_valid); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy got %b expected 0", busy); end
    checks++; if (counts !== '0) begin errors++; $display("FAIL midframe_counts got %h expected 0", counts); end
    checks++; if (spike_valid !== 1'b0) begin errors++; $display("FAIL midframe_spike_valid got %b expected 0", spike_valid); end
    p = dut.g_neuron[3].u_neuron.pot_q;
    checks++; if (p !== 16'sd0) begin errors++; $display("FAIL midframe_pot3 got %0d expected 0", p); end
    @(negedge clk);
    rst = 1'b1;
    run_frame(7'b1111111, 1'b0, 1'b0, 0, 0, 9'h000);
    $display("frame after reset, no reload: done at %0d counts %h", done_cyc, counts);
    checks++; if (done_cyc !== 129) begin errors++; $display("FAIL postreset_done_cycle got %0d expected 129", done_cyc); end
    checks++; if (counts !== '0) begin errors++; $display("FAIL postreset_counts got %h expected 0", counts); end
    p = dut.g_neuron[1].u_neuron.pot_q;
    checks++; if (p !== 16'sd0) begin errors++; $display("FAIL postreset_pot1 got %0d expected 0", p); end
    load_weights(9'h03C, 9'h104, 9'h100, 9'h064);
    run_frame(7'b0101010, 1'b0, 1'b0, 0, 0, 9'h000);
    $display("frame A after reload: done at %0d counts %0d %0d", done_cyc, cnt_of(0), cnt_of(3));
    checks++; if (done_cyc !== 129) begin errors++; $display("FAIL reload_done_cycle got %0d expected 129", done_cyc); end
    checks++; if (cnt_of(0) !== 8) begin errors++; $display("FAIL reload_count0 got %0d expected 8", cnt_of(0)); end
    p = dut.g_neuron[1].u_neuron.pot_q;
    checks++; if (p !== -16'sd176) begin errors++; $display("FAIL reload_pot1 got %0d expected -176", p); end
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    w_we   = 1'b0;
    pixels = '0;
    w_in   = '0;
    w_out  = '0;
    w_data = '0;
    test_reset;
    test_frame_basic;
    test_neg_zero;
    test_busy_ignores;
    test_threshold_boundary;
    test_out_of_range_and_coincident;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_layer.md
SNN_LAYER -- requirements
Module: snn_layer

Interface
REQ-001 SHALL have parameter N_IN, default 7, number of binary input channels (pixels).
REQ-002 SHALL have parameter N_OUT, default 4, number of integrate-and-fire output neurons.
REQ-003 SHALL have parameter WIDTH, default 8; weights are WIDTH+1-bit sign-magnitude (bit WIDTH = sign, 1 = negative).
REQ-004 SHALL have parameter POT_W, default 16, signed membrane-potential width.
REQ-005 SHALL have parameter THRESH, default 256, firing threshold; LEAK, default 1, per-timestep decay toward zero; STEPS, default 1024, timesteps per frame.
REQ-006 SHALL derive CNT_W = $clog2(STEPS+1) for spike counters.
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 pixels  input  N_IN  binary input frame, sampled on an accepted start.
REQ-010 start  input  1  one-cycle frame request.
REQ-011 w_we, w_in, w_out, w_data  input  1, $clog2(N_IN), $clog2(N_OUT), WIDTH+1  weight write port for weight[w_out][w_in].
REQ-012 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-013 spikes, spike_valid  output  N_OUT, 1  per-timestep spike vector and its one-cycle qualifier.
REQ-014 done  output  1  one-cycle pulse at frame end; counts  output  N_OUT*CNT_W  per-neuron spike totals, neuron k at [k*CNT_W +: CNT_W].

Function
REQ-015 FSM SHALL have states IDLE, ACCUM, FIRE, DONE; reset state IDLE.
REQ-016 IDLE: on start, the block SHALL latch pixels, clear all potentials and counts, zero the input index and timestep counter, and go to ACCUM next cycle.
REQ-017 ACCUM: the block SHALL spend exactly N_IN cycles, one per input index i = 0..N_IN-1; if latched pixel i = 1, it adds signed weight[k][i] to potential k for all k in parallel.
REQ-018 Sign-magnitude -0 SHALL count as 0; adds SHALL saturate at the POT_W signed limits, with no wrap.
REQ-019 FIRE (1 cycle): the block SHALL apply leak (pot > 0: pot - min(LEAK, pot); pot < 0: pot + min(LEAK, -pot)), then compare the result to THRESH.
REQ-020 In FIRE, if the leaked pot >= THRESH, the block SHALL raise spikes[k], reset pot k to 0 and increment count k (saturating at 2^CNT_W-1); otherwise it stores the leaked pot. spike_valid SHALL be high in this cycle.
REQ-021 After FIRE, the block SHALL increment the timestep; if it equals STEPS, go to DONE, else go to ACCUM with i = 0.
REQ-022 DONE (1 cycle): the block SHALL assert done and go to IDLE; counts SHALL hold until the next accepted start.
REQ-023 Latency: an accepted start at cycle 0 SHALL give done at cycle 1 + STEPS*(N_IN+1).
REQ-024 start while busy SHALL be ignored; a start in the DONE cycle SHALL be ignored.
REQ-025 w_we SHALL write only in IDLE; w_we while busy SHALL be dropped, and weights SHALL be unchanged. A write coincident with an accepted start SHALL take effect before the first ACCUM.
REQ-026 Out-of-range w_in/w_out SHALL be ignored.

Reset
REQ-027 rst low SHALL force IDLE, busy = 0, done = 0, spike_valid = 0, spikes = 0, counts = 0, all potentials = 0, and all weights = 0, immediately and mid-frame.
REQ-028 After rst release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-029 Package snn_pkg SHALL hold the FSM state enum, the sign-magnitude-to-signed conversion function, and the saturating add function.
REQ-030 Sub-module lif_neuron SHALL implement one neuron (potential, leak, threshold, counter), instantiated N_OUT times via generate.

Verification (N_IN=7, N_OUT=4, WIDTH=8, THRESH=256, LEAK=1, STEPS=16)
REQ-031 weight[0][*] = +60, pixels = 7'b0101010, start -> neuron 0 spikes every 2nd timestep, counts[0] = 8, done at cycle 129.
REQ-032 weight[1][*] = 9'b1_0000_0100 (-4), same pixels -> counts[1] = 0, pot1 = -176 at done.
REQ-033 weight[2][*] = 9'b1_0000_0000 (-0), all pixels 1 -> counts[2] = 0, pot2 = 0 throughout.
REQ-034 start pulsed at cycles 5 and 129 during the frame -> ignored, single done at cycle 129; w_we at cycle 10 -> weights unchanged.
REQ-035 rst low at cycle 40 -> busy, counts, weights = 0 immediately; after reload and start, REQ-031 result reproduced.
